// File: rtl/exec_pkg.sv
// Shared op codes, FSM states and iterative-core modes for mc_exec_unit.
// EXEC_DIV_EN selects whether DIVU/REMU are iterative ops or illegal codes.
package exec_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  typedef enum logic [1:0] {ModeMul, ModeDiv, ModeRem} iter_mode_e;

  function automatic logic is_iter_op(logic [3:0] op);
`ifdef EXEC_DIV_EN
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/exec_iter_core.sv
// Shared shift/accumulate datapath: shift-add MUL and restoring DIVU/REMU, WIDTH steps.
// The first step happens on the start edge; EXEC_DIV_EN adds the divide step.
module exec_iter_core
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  iter_mode_e       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic               run_q, run_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d, x_q, x_d, y_q, y_d;
  iter_mode_e         mode_q, mode_d;

  logic [WIDTH-1:0]   src_acc, src_x, src_y;
  iter_mode_e         src_mode;
`ifdef EXEC_DIV_EN
  logic [WIDTH:0]     rem_sh, trial;
`endif

  assign done   = run_q && (cnt_q == SHAMT_W'(WIDTH - 1));
  // x holds multiplicand/divisor, y holds multiplier/quotient, acc holds product/remainder.
  assign result = (mode_q == ModeDiv) ? y_q : acc_q;

  always_comb begin
    src_mode = start ? mode : mode_q;
    src_acc  = start ? '0 : acc_q;
    if (start) begin
      src_x = (mode == ModeMul) ? a : b;
      src_y = (mode == ModeMul) ? b : a;
    end else begin
      src_x = x_q;
      src_y = y_q;
    end

    run_d  = run_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    x_d    = x_q;
    y_d    = y_q;
    mode_d = mode_q;
`ifdef EXEC_DIV_EN
    rem_sh = '0;
    trial  = '0;
`endif

    if (start || run_q) begin
      mode_d = src_mode;
      run_d  = start || !done;
      cnt_d  = start ? SHAMT_W'(1) : (done ? '0 : cnt_q + SHAMT_W'(1));
`ifdef EXEC_DIV_EN
      if (src_mode != ModeMul) begin
        // Zero divisor never restores: quotient fills with ones, remainder becomes a.
        rem_sh = {src_acc, src_y[WIDTH-1]};
        trial  = rem_sh - {1'b0, src_x};
        x_d    = src_x;
        if (!trial[WIDTH]) begin
          acc_d = trial[WIDTH-1:0];
          y_d   = {src_y[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[WIDTH-1:0];
          y_d   = {src_y[WIDTH-2:0], 1'b0};
        end
      end else
`endif
      begin
        acc_d = src_y[0] ? src_acc + src_x : src_acc;
        x_d   = src_x << 1;
        y_d   = src_y >> 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      mode_q <= ModeMul;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      x_q    <= x_d;
      y_q    <= y_d;
      mode_q <= mode_d;
    end
  end

endmodule

// File: rtl/mc_exec_unit.sv
// Multi-cycle execute unit: single-cycle ALU, iterative MUL and (EXEC_DIV_EN) DIVU/REMU,
// valid/ready in and out, result held in an output register until taken.
module mc_exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             illegal,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             accept, core_start, core_done;
  iter_mode_e       core_mode;
  logic [WIDTH-1:0] core_result;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout, alu_ill;

  logic             out_valid_q, out_valid_d, zero_q, zero_d;
  logic             cout_q, cout_d, illegal_q, illegal_d;
  logic [WIDTH-1:0] result_q, result_d;

  assign in_ready   = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign core_start = accept && is_iter_op(op);
  assign core_mode  = (op == OP_MUL) ? ModeMul : ((op == OP_REMU) ? ModeRem : ModeDiv);

  exec_iter_core #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (core_start),
    .mode  (core_mode),
    .a     (a),
    .b     (b),
    .done  (core_done),
    .result(core_result)
  );

  // SUB as a + ~b + 1 so the top bit is the NOT-borrow.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ill  = 1'b0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD: begin
        alu_res  = sum[WIDTH-1:0];
        alu_cout = sum[WIDTH];
      end
      OP_XOR: alu_res = a ^ b;
      OP_SLL: alu_res = a << b[SHAMT_W-1:0];
      OP_SRL: alu_res = a >> b[SHAMT_W-1:0];
      OP_SUB: begin
        alu_res  = diff[WIDTH-1:0];
        alu_cout = diff[WIDTH];
      end
      OP_SLT: alu_res = {{(WIDTH - 1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef EXEC_DIV_EN
      OP_MUL, OP_DIVU, OP_REMU: ;
`else
      OP_MUL: ;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (core_start) state_d = (op == OP_MUL) ? S_MUL : S_DIV;
      S_MUL, S_DIV: if (core_done) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    cout_d      = cout_q;
    illegal_d   = illegal_q;
    if (accept && !is_iter_op(op)) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      zero_d      = (alu_res == '0);
      cout_d      = alu_cout;
      illegal_d   = alu_ill;
    end else if (state_q == S_DONE) begin
      // The register is always empty here: an iterative op is only accepted when it drains.
      out_valid_d = 1'b1;
      result_d    = core_result;
      zero_d      = (core_result == '0);
      cout_d      = 1'b0;
      illegal_d   = 1'b0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      cout_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      cout_q      <= cout_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign cout      = cout_q;
  assign illegal   = illegal_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mc_exec_unit.sv
// Self-checking bench for mc_exec_unit: directed vector table, corner sequences,
// and random ops against a behavioural model. Honours EXEC_DIV_EN.
module tb_mc_exec_unit;

  localparam int W = 32;
`ifdef EXEC_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, zero, cout, illegal, busy;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mc_exec_unit #(
    .WIDTH  (W),
    .SHAMT_W(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .cout     (cout),
    .illegal  (illegal),
    .busy     (busy)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         cout;
    logic         ill;
    int           lat;
  } exp_t;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain arithmetic on wide integers.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint unsigned ux, uy, full;
    ux = x;
    uy = y;
    e.res = '0;
    e.cout = 1'b0;
    e.ill = 1'b0;
    e.lat = 1;
    case (o)
      4'd0: e.res = x & y;
      4'd1: e.res = x | y;
      4'd2: begin full = ux + uy; e.res = full[31:0]; e.cout = full[32]; end
      4'd3: e.res = x ^ y;
      4'd4: e.res = x << y[4:0];
      4'd5: e.res = x >> y[4:0];
      4'd6: begin e.res = x - y; e.cout = (x >= y); end
      4'd7: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd8: begin full = ux * uy; e.res = full[31:0]; e.lat = W + 1; end
      4'd9, 4'd10: begin
        if (DivEn) begin
          e.lat = W + 1;
          if (y == 0) e.res = (o == 4'd9) ? '1 : x;
          else        e.res = (o == 4'd9) ? x / y : x % y;
        end else begin
          e.ill = 1'b1;
        end
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  function automatic bit model_is_iter(input logic [3:0] o);
    return (o == 4'd8) || (DivEn && (o == 4'd9 || o == 4'd10));
  endfunction

  task automatic add_vec(input string name, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] res, input logic z,
                         input logic c, input logic il, input int lat);
    vec_t v;
    v.name = name; v.op = o; v.a = x; v.b = y;
    v.e.res = res; v.e.zero = z; v.e.cout = c; v.e.ill = il; v.e.lat = lat;
    tbl.push_back(v);
  endtask

  // Issue one op with out_ready high; check latency, busy cycles and outputs.
  task automatic run_and_check(input string name, input logic [3:0] o, input logic [W-1:0] x,
                               input logic [W-1:0] y, input exp_t e);
    int t, lat, busy_n;
    t = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    chk({name, " in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    busy_n = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_n++;
      @(posedge clk); #1; lat++;
    end
    chk({name, " latency"}, lat, e.lat);
    chk({name, " busy_cycles"}, busy_n, e.lat - 1);
    chk({name, " busy_at_out"}, busy, 0);
    chk({name, " result"}, result, e.res);
    chk({name, " zero"}, zero, e.zero);
    chk({name, " cout"}, cout, e.cout);
    chk({name, " illegal"}, illegal, e.ill);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int seen;
    exp_t e;
    logic [3:0] ro;
    logic [W-1:0] ra, rb;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst result", result, 0);
    chk("rst flags", {zero, cout, illegal}, 0);
    rst_n = 1'b1;
    #1;
    chk("rst in_ready", in_ready, 1);

    // Directed vectors, expected values worked out by hand
    add_vec("add_wrap", 4'h2, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 1, 0, 1);
    add_vec("sub_neg", 4'h6, 32'h5, 32'h7, 32'hFFFF_FFFE, 0, 0, 0, 1);
    add_vec("sub_pos", 4'h6, 32'h7, 32'h5, 32'h2, 0, 1, 0, 1);
    add_vec("slt", 4'h7, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 0, 0, 1);
    add_vec("and", 4'h0, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'h0505_0505, 0, 0, 0, 1);
    add_vec("or", 4'h1, 32'hF0, 32'h0F, 32'hFF, 0, 0, 0, 1);
    add_vec("xor", 4'h3, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 0, 0, 0, 1);
    add_vec("sll_mask", 4'h4, 32'h1, 32'h3F, 32'h8000_0000, 0, 0, 0, 1);
    add_vec("srl_mask", 4'h5, 32'h8000_0000, 32'h24, 32'h0800_0000, 0, 0, 0, 1);
    add_vec("illegal_f", 4'hF, 32'h1234, 32'h5678, 32'h0, 1, 0, 1, 1);
    add_vec("mul", 4'h8, 32'd12345, 32'd678, 32'd8369910, 0, 0, 0, 33);
    add_vec("mul_ovf", 4'h8, 32'h8000_0000, 32'h2, 32'h0, 1, 0, 0, 33);
    add_vec("divu", 4'h9, 32'd100, 32'd7, DivEn ? 32'd14 : 32'd0, !DivEn, 0, !DivEn,
            DivEn ? 33 : 1);
    add_vec("remu", 4'hA, 32'd100, 32'd7, DivEn ? 32'd2 : 32'd0, !DivEn, 0, !DivEn,
            DivEn ? 33 : 1);
    add_vec("divu_z", 4'h9, 32'd9, 32'd0, DivEn ? 32'hFFFF_FFFF : 32'd0, !DivEn, 0, !DivEn,
            DivEn ? 33 : 1);
    add_vec("remu_z", 4'hA, 32'd9, 32'd0, DivEn ? 32'd9 : 32'd0, !DivEn, 0, !DivEn,
            DivEn ? 33 : 1);
    for (int i = 0; i < tbl.size(); i++) begin
      run_and_check(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
    end

    // Random iterative ops against the model
    for (int i = 0; i < 8; i++) begin
      ro = (i % 3 == 0) ? 4'h8 : ((i % 3 == 1) ? 4'h9 : 4'hA);
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : $urandom;
      run_and_check("rand_iter", ro, ra, rb, model(ro, ra, rb));
    end

    // Reset in the middle of a MUL aborts it
    op = 4'h8; a = 32'd12345; b = 32'd678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("midrst busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("midrst in_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst stale_result", seen, 0);

    // Backpressure: ADD 3+4 held for 5 cycles, next op waiting
    out_ready = 1'b0;
    op = 4'h2; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 4'h1; a = 32'd8; b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid", out_valid, 1);
      chk("bp result_held", result, 32'd7);
      chk("bp in_ready_low", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp in_ready_release", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp next_valid", out_valid, 1);
    chk("bp next_result", result, 32'd9);
    @(posedge clk); #1;
    chk("bp drained", out_valid, 0);

    // Stream of single-cycle ops, one per cycle
    out_ready = 1'b1;
    in_valid = 1'b1;
    op = 4'hF; a = $urandom; b = $urandom;
    for (int i = 0; i < 100; i++) begin
      chk("stream in_ready", in_ready, 1);
      e = model(op, a, b);
      @(posedge clk); #1;
      chk("stream out_valid", out_valid, 1);
      chk("stream result", result, e.res);
      chk("stream flags", {zero, cout, illegal}, {e.zero, e.cout, e.ill});
      ro = 4'($urandom_range(0, 15));
      if (model_is_iter(ro)) ro = 4'hF;
      op = ro;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream end", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
